// File: rtl/btb.sv
`default_nettype none
// ============================================================================
// Module   : btb (with riscv_pkg)
// Brief    : Direct-mapped branch target buffer with 2-bit saturating
//            direction counters, zero-cycle combinational lookup and a
//            single-entry update port driven from EX.
// Revision : 1.0 - initial release
// ============================================================================

package riscv_pkg;
  parameter int XLEN = 32;
endpackage

module btb #(
  parameter int ENTRIES = 64,
  parameter int XLEN    = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            btb_hit,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  output logic [XLEN-1:0] next_pc,
  input  logic            btb_update_en,
  input  logic [XLEN-1:0] btb_pc_update,
  input  logic [XLEN-1:0] btb_target_actual,
  input  logic            btb_is_branch_or_jmp,
  input  logic            btb_flush
);

  localparam int C_IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int C_TAG_W = XLEN - C_IDX_W - 2;

  // Entry storage; only the valid bits carry reset, the rest is masked by them
  logic [ENTRIES-1:0] r_valid;
  logic [C_TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [C_IDX_W-1:0] w_lk_idx;
  logic [C_TAG_W-1:0] w_lk_tag;
  logic [C_IDX_W-1:0] w_up_idx;
  logic [C_TAG_W-1:0] w_up_tag;
  logic               w_up_hit;
  logic               w_up_act;
  logic [3:0]         w_unused_bits;

  assign w_lk_idx = if_pc[C_IDX_W+1:2];
  assign w_lk_tag = if_pc[XLEN-1:C_IDX_W+2];
  assign w_up_idx = btb_pc_update[C_IDX_W+1:2];
  assign w_up_tag = btb_pc_update[XLEN-1:C_IDX_W+2];

  // Byte-offset bits never participate in indexing or tag match
  assign w_unused_bits = {if_pc[1:0], btb_pc_update[1:0]};

  // An update only counts when neither reset nor flush wipes the table
  assign w_up_act = btb_update_en && !reset && !btb_flush;
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // Combinational lookup against pre-update contents (no write bypass)
  always_comb begin
    btb_hit        = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    predict_taken  = btb_hit && r_ctr[w_lk_idx][1];
    predict_target = btb_hit ? r_target[w_lk_idx] : '0;
    next_pc        = predict_taken ? predict_target : (if_pc + XLEN'(4));
  end

  // Valid bits: reset and flush clear everything, a taken update allocates
  always_ff @(posedge clk) begin
    if (reset || btb_flush) begin
      r_valid <= '0;
    end else if (btb_update_en && btb_is_branch_or_jmp) begin
      r_valid[w_up_idx] <= 1'b1;
    end
  end

  // Tag/target/counter of the single indexed entry on a qualifying update
  always_ff @(posedge clk) begin
    if (w_up_act) begin
      if (btb_is_branch_or_jmp) begin
        r_target[w_up_idx] <= btb_target_actual;
        if (w_up_hit) begin
          r_ctr[w_up_idx] <= (r_ctr[w_up_idx] == 2'b11) ? 2'b11
                                                         : r_ctr[w_up_idx] + 2'd1;
        end else begin
          r_tag[w_up_idx] <= w_up_tag;
          r_ctr[w_up_idx] <= 2'b10;
        end
      end else if (w_up_hit) begin
        r_ctr[w_up_idx] <= (r_ctr[w_up_idx] == 2'b00) ? 2'b00
                                                       : r_ctr[w_up_idx] - 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btb.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb
// Brief    : Self-checking bench for btb: behavioural table model compared
//            every cycle, directed scenarios with literal expectations, then
//            randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================

module tb_btb;

  localparam int ENTRIES = 64;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        btb_hit;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic [31:0] next_pc;
  logic        btb_update_en;
  logic [31:0] btb_pc_update;
  logic [31:0] btb_target_actual;
  logic        btb_is_branch_or_jmp;
  logic        btb_flush;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  btb #(.ENTRIES(ENTRIES)) dut (
    .clk                  (clk),
    .reset                (reset),
    .if_pc                (if_pc),
    .btb_hit              (btb_hit),
    .predict_taken        (predict_taken),
    .predict_target       (predict_target),
    .next_pc              (next_pc),
    .btb_update_en        (btb_update_en),
    .btb_pc_update        (btb_pc_update),
    .btb_target_actual    (btb_target_actual),
    .btb_is_branch_or_jmp (btb_is_branch_or_jmp),
    .btb_flush            (btb_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each slot remembers the word address (pc>>2) it holds, its target
  // and a 0..3 confidence count.
  bit          m_valid  [ENTRIES];
  logic [29:0] m_word   [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int s = slot_of(pc);
    return m_valid[s] && (m_word[s] == pc[31:2]);
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[slot_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_tgt(input logic [31:0] pc);
    return m_hit(pc) ? m_target[slot_of(pc)] : 32'h0;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    logic [31:0] seq = pc + 32'd4;
    return m_taken(pc) ? m_tgt(pc) : seq;
  endfunction

  task automatic model_update();
    int s;
    if (reset || btb_flush) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    end else if (btb_update_en) begin
      s = slot_of(btb_pc_update);
      if (btb_is_branch_or_jmp) begin
        if (m_hit(btb_pc_update)) begin
          m_target[s] = btb_target_actual;
          m_ctr[s]    = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
        end else begin
          m_valid[s]  = 1;
          m_word[s]   = btb_pc_update[31:2];
          m_target[s] = btb_target_actual;
          m_ctr[s]    = 2;
        end
      end else if (m_hit(btb_pc_update)) begin
        m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t pc=0x%08h)",
               name, act, exp, $time, if_pc);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (started) begin
      chk("model_hit",    32'(btb_hit),       32'(m_hit(if_pc)));
      chk("model_taken",  32'(predict_taken), 32'(m_taken(if_pc)));
      chk("model_target", predict_target,     m_tgt(if_pc));
      chk("model_next",   next_pc,            m_next(if_pc));
    end
  end

  // Drive one cycle's inputs and let them settle before the compare edge
  task automatic apply(input logic rs, input logic [31:0] pc, input logic ue,
                       input logic [31:0] up, input logic [31:0] tg,
                       input logic tk, input logic fl);
    reset = rs; if_pc = pc; btb_update_en = ue; btb_pc_update = up;
    btb_target_actual = tg; btb_is_branch_or_jmp = tk; btb_flush = fl;
    #2;
  endtask

  task automatic look(input logic [31:0] pc);
    apply(1'b0, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  logic [31:0] rpc;
  logic [31:0] rup;

  initial begin
    apply(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    model_update();
    started = 1;
    #1;
    apply(1'b1, 32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1);
    tick();

    // Cold table after reset
    look(32'h100);
    chk("rst_hit", 32'(btb_hit), 32'h0);
    chk("rst_taken", 32'(predict_taken), 32'h0);
    chk("rst_next", next_pc, 32'h104);
    tick();

    // Allocate, same-cycle lookup sees old contents
    apply(1'b0, 32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0);
    chk("alloc_same_cycle_hit", 32'(btb_hit), 32'h0);
    tick();
    look(32'h100);
    chk("alloc_hit", 32'(btb_hit), 32'h1);
    chk("alloc_taken", 32'(predict_taken), 32'h1);
    chk("alloc_next", next_pc, 32'h200);
    tick();

    // Three not-taken: ctr 2->1->0->0
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 32'h100, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0);
      tick();
    end
    look(32'h100);
    chk("nt_hit", 32'(btb_hit), 32'h1);
    chk("nt_taken", 32'(predict_taken), 32'h0);
    chk("nt_next", next_pc, 32'h104);
    tick();
    apply(1'b0, 32'h100, 1'b1, 32'h100, 32'h240, 1'b1, 1'b0);
    tick();
    look(32'h100);
    chk("retrain_taken", 32'(predict_taken), 32'h0);
    chk("retrain_target", predict_target, 32'h240);
    tick();

    // Aliasing at slot 0
    look(32'h1100);
    chk("alias_miss", 32'(btb_hit), 32'h0);
    tick();
    apply(1'b0, 32'h1100, 1'b1, 32'h1100, 32'h999, 1'b0, 1'b0);
    tick();
    look(32'h100);
    chk("alias_nt_keep", 32'(btb_hit), 32'h1);
    tick();
    apply(1'b0, 32'h1100, 1'b1, 32'h1100, 32'h300, 1'b1, 1'b0);
    tick();
    look(32'h1100);
    chk("alias_new_hit", 32'(btb_hit), 32'h1);
    chk("alias_new_next", next_pc, 32'h300);
    tick();
    look(32'h100);
    chk("alias_old_miss", 32'(btb_hit), 32'h0);
    tick();

    // Fill four slots, then flush with a simultaneous update
    for (int i = 1; i <= 4; i++) begin
      apply(1'b0, 32'h100, 1'b1, 32'h100 + 32'(4 * i), 32'h800 + 32'(i), 1'b1, 1'b0);
      tick();
    end
    look(32'h108);
    chk("fill_hit", 32'(btb_hit), 32'h1);
    tick();
    apply(1'b0, 32'h104, 1'b1, 32'h140, 32'h500, 1'b1, 1'b1);
    tick();
    look(32'h140);
    chk("flush_upd_miss", 32'(btb_hit), 32'h0);
    tick();
    look(32'h10C);
    chk("flush_fill_miss", 32'(btb_hit), 32'h0);
    tick();

    // Reset overrides a simultaneous taken update and wipes learned state
    apply(1'b0, 32'h180, 1'b1, 32'h180, 32'h400, 1'b1, 1'b0);
    tick();
    apply(1'b1, 32'h180, 1'b1, 32'h180, 32'h400, 1'b1, 1'b0);
    tick();
    look(32'h180);
    chk("rst_upd_miss", 32'(btb_hit), 32'h0);
    tick();
    look(32'hFFFF_FFFC);
    chk("wrap_next", next_pc, 32'h0000_0000);
    tick();

    // Randomized traffic over a small address pool to force hits and aliases
    for (int n = 0; n < 3000; n++) begin
      rpc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
      rup = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) rpc = 32'hFFFF_FFFC;
      if ($urandom_range(0, 49) == 0) rup = 32'hFFFF_FFFC;
      apply(($urandom_range(0, 99) < 2), rpc, ($urandom_range(0, 9) < 6), rup,
            $urandom, $urandom_range(0, 1) == 1, ($urandom_range(0, 99) < 3));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btb.md
BTB -- requirements
Module: btb

Interface
REQ-001 Parameter: ENTRIES, default 64, number of direct-mapped entries; power of two, 2..1024.
REQ-002 Parameter: XLEN, taken from riscv_pkg (32), address and target width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: if_pc  input  XLEN  fetch PC to look up.
REQ-006 Port: btb_hit  output  1  if_pc matches a valid entry.
REQ-007 Port: predict_taken  output  1  predicted taken for if_pc.
REQ-008 Port: predict_target  output  XLEN  stored target of the matching entry; 0 on miss.
REQ-009 Port: next_pc  output  XLEN  predict_taken ? predict_target : if_pc + 4.
REQ-010 Port: btb_update_en  input  1  resolved instruction in EX this cycle.
REQ-011 Port: btb_pc_update  input  XLEN  PC of the resolved instruction.
REQ-012 Port: btb_target_actual  input  XLEN  resolved target.
REQ-013 Port: btb_is_branch_or_jmp  input  1  resolved instruction was a taken branch or jump.
REQ-014 Port: btb_flush  input  1  invalidate all entries (fence.i / context change).

Function
REQ-015 Index = pc[IDX+1:2] with IDX = log2(ENTRIES); tag = pc[XLEN-1:IDX+2]; pc[1:0] ignored.
REQ-016 Each entry holds: valid (1), tag, target (XLEN), 2-bit saturating counter ctr.
REQ-017 Lookup is combinational, zero cycles: btb_hit = valid[idx] && tag[idx] == tag(if_pc).
REQ-018 predict_taken = btb_hit && ctr[idx][1]; predict_target = btb_hit ? target[idx] : 0.
REQ-019 next_pc addition wraps modulo 2^XLEN (0xFFFF_FFFC + 4 = 0x0000_0000).
REQ-020 Updates take effect at the clock edge following btb_update_en = 1; there is no lookup bypass, so a same-cycle lookup sees pre-update contents.
REQ-021 Update, taken, tag hit: target <= btb_target_actual; ctr <= min(ctr+1, 3).
REQ-022 Update, taken, miss (invalid entry or tag mismatch): allocate/overwrite the entry with valid=1, new tag, target <= btb_target_actual, ctr <= 2'b10.
REQ-023 Update, not taken, tag hit: ctr <= max(ctr-1, 0); entry remains valid; target unchanged.
REQ-024 Update, not taken, miss: no state change.
REQ-025 btb_update_en = 0: no state change regardless of the other update inputs.
REQ-026 btb_flush = 1: all valid bits clear at the next edge; flush takes priority over a simultaneous update, whose effect is discarded.
REQ-027 Only the single indexed entry is modified per update; all other entries hold their state.

Reset
REQ-028 While reset = 1, all valid bits clear at the edge; flush and update in the same cycle are ignored.
REQ-029 Tags, targets and counters need not be reset; valid = 0 masks them.
REQ-030 After reset: btb_hit = 0, predict_taken = 0, predict_target = 0, next_pc = if_pc + 4 for every if_pc.
REQ-031 Reset asserted mid-operation discards all learned entries; the first post-reset cycle behaves as REQ-030.

Verification
REQ-032 Reset, then if_pc = 0x0000_0100 -> btb_hit = 0, predict_taken = 0, next_pc = 0x0000_0104.
REQ-033 Update (pc = 0x100, target = 0x200, taken = 1), then lookup 0x100 -> hit = 1, taken = 1 (ctr = 2), next_pc = 0x200; a same-cycle lookup during the update -> hit = 0.
REQ-034 Three not-taken updates at 0x100 after REQ-033 -> ctr goes 1, 0, 0; lookup gives hit = 1, taken = 0, next_pc = 0x104; one taken update (target 0x240) -> ctr = 1, still taken = 0, predict_target = 0x240.
REQ-035 Alias with ENTRIES = 64: 0x100 allocated, lookup 0x1100 -> hit = 0; not-taken update at 0x1100 -> no change; taken update at 0x1100 (target 0x300) -> 0x1100 hits with next_pc = 0x300, and 0x100 now misses.
REQ-036 Fill 4 distinct indices, then btb_flush = 1 with a simultaneous taken update at 0x140 -> next cycle all lookups, including 0x140, miss.
REQ-037 Taken update with reset = 1 in the same cycle -> next cycle the entry misses; lookup of 0xFFFF_FFFC on a miss -> next_pc = 0x0000_0000.
